// File: rtl/video_color_out_pkg.sv
// Shared types and constants for the pixel output stage behind the color RAM.
package gfx_video_pkg;

    localparam int CH_W     = 4;
    localparam int OUT_W    = 8;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [CH_W-1:0] i;
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } color_word_t;

    // Bar k lights red/green/blue from k[2]/k[1]/k[0] at full intensity.
    function automatic color_word_t bar_word(input logic [2:0] k);
        color_word_t w;
        w.i = {CH_W{1'b1}};
        w.r = {CH_W{k[2]}};
        w.g = {CH_W{k[1]}};
        w.b = {CH_W{k[0]}};
        return w;
    endfunction

endpackage

// File: rtl/video_color_out_if.sv
// Pixel-side bundle: color word, syncs and strobe in; scaled RGB and aligned syncs out.
interface video_color_out_if;
    import gfx_video_pkg::*;

    logic                 pix_en;
    logic [4*CH_W-1:0]    D;
    logic                 blank_b;
    logic                 hsync_b;
    logic                 vsync_b;
    logic                 test_en;
    logic [OUT_W-1:0]     r;
    logic [OUT_W-1:0]     g;
    logic [OUT_W-1:0]     b;
    logic                 blank_out_b;
    logic                 hsync_out_b;
    logic                 vsync_out_b;

    modport master (
        output pix_en, D, blank_b, hsync_b, vsync_b, test_en,
        input  r, g, b, blank_out_b, hsync_out_b, vsync_out_b
    );

    modport slave (
        input  pix_en, D, blank_b, hsync_b, vsync_b, test_en,
        output r, g, b, blank_out_b, hsync_out_b, vsync_out_b
    );

endinterface

// File: rtl/video_color_out_intensity_scale.sv
// One channel of intensity scaling: C*(I+1), at most 15*16 = 240 so 8 bits never overflow.
module intensity_scale
    import gfx_video_pkg::*;
(
    input  logic [CH_W-1:0]  c,
    input  logic [CH_W-1:0]  i,
    output logic [OUT_W-1:0] scaled
);

    logic [OUT_W-1:0] c_ext;
    logic [OUT_W-1:0] gain;

    assign c_ext  = {{(OUT_W-CH_W){1'b0}}, c};
    assign gain   = {{(OUT_W-CH_W){1'b0}}, i} + OUT_W'(1);
    assign scaled = c_ext * gain;

endmodule

// File: rtl/video_color_out.sv
// Three-stage pixel output pipeline: capture, intensity scale, blank; plus color bars and frame count.
module video_color_out
    import gfx_video_pkg::*;
#(
    parameter int BAR_W  = 42,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    video_color_out_if.slave  vid,
    output logic [FCNT_W-1:0] frame_cnt
);

    // Wide enough to pass the last bar before saturating.
    localparam int HC_W = $clog2(8 * BAR_W) + 1;

    logic [HC_W-1:0]  hcount;
    logic [HC_W-1:0]  bar_q;
    logic [2:0]       bar_k;
    color_word_t      in_word;

    color_word_t      s1_word;
    logic             s1_blank, s1_hs, s1_vs;

    logic [OUT_W-1:0] scaled_r, scaled_g, scaled_b;
    logic [OUT_W-1:0] s2_r, s2_g, s2_b;
    logic             s2_blank, s2_hs, s2_vs;

    logic [OUT_W-1:0] out_r, out_g, out_b;
    logic             out_blank, out_hs, out_vs;
    logic             vs_hist;

    assign bar_q = hcount / HC_W'(BAR_W);

    always_comb begin
        bar_k = bar_q[2:0];
        if (bar_q > HC_W'(7)) begin
            bar_k = 3'd7;
        end
        in_word = vid.test_en ? bar_word(bar_k) : color_word_t'(vid.D);
    end

    intensity_scale u_scale_r (.c(s1_word.r), .i(s1_word.i), .scaled(scaled_r));
    intensity_scale u_scale_g (.c(s1_word.g), .i(s1_word.i), .scaled(scaled_g));
    intensity_scale u_scale_b (.c(s1_word.b), .i(s1_word.i), .scaled(scaled_b));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hcount    <= '0;
            s1_word   <= '0;
            s1_blank  <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s2_r      <= '0;
            s2_g      <= '0;
            s2_b      <= '0;
            s2_blank  <= 1'b0;
            s2_hs     <= 1'b1;
            s2_vs     <= 1'b1;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_blank <= 1'b0;
            out_hs    <= 1'b1;
            out_vs    <= 1'b1;
            vs_hist   <= 1'b1;
            frame_cnt <= '0;
        end else if (vid.pix_en) begin
            if (!vid.blank_b) begin
                hcount <= '0;
            end else if (hcount != '1) begin
                hcount <= hcount + HC_W'(1);
            end

            s1_word  <= in_word;
            s1_blank <= vid.blank_b;
            s1_hs    <= vid.hsync_b;
            s1_vs    <= vid.vsync_b;

            s2_r     <= scaled_r;
            s2_g     <= scaled_g;
            s2_b     <= scaled_b;
            s2_blank <= s1_blank;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;

            out_r     <= s2_blank ? s2_r : '0;
            out_g     <= s2_blank ? s2_g : '0;
            out_b     <= s2_blank ? s2_b : '0;
            out_blank <= s2_blank;
            out_hs    <= s2_hs;
            out_vs    <= s2_vs;

            // A frame completes when the aligned vsync is seen falling.
            vs_hist <= out_vs;
            if (vs_hist && !out_vs) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign vid.r           = out_r;
    assign vid.g           = out_g;
    assign vid.b           = out_b;
    assign vid.blank_out_b = out_blank;
    assign vid.hsync_out_b = out_hs;
    assign vid.vsync_out_b = out_vs;

endmodule
